mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/cl_arb_priority.sv | 32 +++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: core state, read-owner tags
// and the starvation counter width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_NET  = 2'd2
    } arb_owner_e;

    // A limit of 0 still needs a 1-bit register; it simply never leaves 0.
    function automatic int unsigned starve_cnt_w(input int unsigned max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/cl_arb_priority.sv
// Combinational grant selection between the core and network requesters,
// driven by core state and the starvation-hit flag.
module cl_arb_priority
    import mem_port_arbiter_pkg::*;
(
    input  state_e state_i,
    input  logic   core_req_i,
    input  logic   net_req_i,
    input  logic   starve_hit_i,
    output logic   core_gnt_o,
    output logic   net_gnt_o
);

    always_comb begin
        core_gnt_o = 1'b0;
        net_gnt_o  = 1'b0;
        case (state_i)
            RUN: begin
                if (starve_hit_i && net_req_i) begin
                    net_gnt_o = 1'b1;
                end else if (core_req_i) begin
                    core_gnt_o = 1'b1;
                end else begin
                    net_gnt_o = net_req_i;
                end
            end
            IDLE, ERR: net_gnt_o = net_req_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between a core and a network requester.
// Define ARB_STARVE_EN to bound network starvation in RUN via STARVE_MAX.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  state_e            core_state_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    input  logic              net_req_i,
    input  logic              net_we_i,
    input  logic [ADDR_W-1:0] net_addr_i,
    input  logic [DATA_W-1:0] net_wdata_i,
    output logic              net_gnt_o,
    output logic              net_rvalid_o,
    output logic [DATA_W-1:0] net_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic       core_gnt_raw;
    logic       net_gnt_raw;
    logic       starve_hit;
    arb_owner_e owner_q;
    arb_owner_e owner_d;

`ifdef ARB_STARVE_EN
    localparam int unsigned CNT_W = starve_cnt_w(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            starve_cnt <= '0;
        end else if (!net_req_i || net_gnt_o) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign starve_hit = (starve_cnt == CNT_MAX);
`else
    // Counter compiled out: the comparison is constant false.
    assign starve_hit = (STARVE_MAX < 0);
`endif

    cl_arb_priority u_prio (
        .state_i      (core_state_i),
        .core_req_i   (core_req_i),
        .net_req_i    (net_req_i),
        .starve_hit_i (starve_hit),
        .core_gnt_o   (core_gnt_raw),
        .net_gnt_o    (net_gnt_raw)
    );

    // Grants are combinational, so they must be masked during reset too.
    assign core_gnt_o   = core_gnt_raw & n_reset;
    assign net_gnt_o    = net_gnt_raw & n_reset;
    assign core_stall_o = core_req_i & ~core_gnt_o;
    assign mem_en_o     = core_gnt_o | net_gnt_o;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        owner_d     = OWN_NONE;
        if (core_gnt_o) begin
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            if (!core_we_i) owner_d = OWN_CORE;
        end else if (net_gnt_o) begin
            mem_we_o    = net_we_i;
            mem_addr_o  = net_addr_i;
            mem_wdata_o = net_wdata_i;
            if (!net_we_i) owner_d = OWN_NET;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign core_rvalid_o = (owner_q == OWN_CORE);
    assign net_rvalid_o  = (owner_q == OWN_NET);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign net_rdata_o   = net_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural memory
// and a rule-level grant model; honours ARB_STARVE_EN like the design.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    state_e        core_state;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          net_req, net_we;
    logic [AW-1:0] net_addr;
    logic [DW-1:0] net_wdata;
    logic          net_gnt, net_rvalid;
    logic [DW-1:0] net_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .core_state_i (core_state),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_gnt_o   (core_gnt),
        .core_stall_o (core_stall),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .net_req_i    (net_req),
        .net_we_i     (net_we),
        .net_addr_i   (net_addr),
        .net_wdata_i  (net_wdata),
        .net_gnt_o    (net_gnt),
        .net_rvalid_o (net_rvalid),
        .net_rdata_o  (net_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory: synchronous read, data valid the cycle after enable.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state.
    typedef struct {
        arb_owner_e  who;
        logic [DW-1:0] data;
        int unsigned due;
    } resp_t;

    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    resp_t         sb[$];
    int unsigned   net_wait = 0;
    logic          last_core_gnt = 1'b0;
    logic          last_net_gnt  = 1'b0;
    int unsigned   dut_net_gnts  = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_core(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = r; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_net(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        net_req = r; net_we = we; net_addr = a; net_wdata = d;
    endtask

    // Applies the arbitration rules to the inputs of the current cycle.
    task automatic eval_cycle();
        logic eg_core, eg_net, starved;
        eg_core = 1'b0;
        eg_net  = 1'b0;
        starved = 1'b0;
`ifdef ARB_STARVE_EN
        starved = net_req && (net_wait == SMAX);
`endif
        if (n_reset) begin
            if (core_state == RUN) begin
                if (starved)       eg_net  = 1'b1;
                else if (core_req) eg_core = 1'b1;
                else               eg_net  = net_req;
            end else begin
                eg_net = net_req;
            end
        end
        dut_net_gnts += int'(net_gnt);

        check("core_gnt", 32'(core_gnt), 32'(eg_core));
        check("net_gnt", 32'(net_gnt), 32'(eg_net));
        check("core_stall", 32'(core_stall), 32'(core_req & ~eg_core));
        check("mem_en", 32'(mem_en), 32'(eg_core | eg_net));
        if (eg_core) begin
            check("mem_we", 32'(mem_we), 32'(core_we));
            check("mem_addr", 32'(mem_addr), 32'(core_addr));
            if (core_we) check("mem_wdata", mem_wdata, core_wdata);
        end else if (eg_net) begin
            check("mem_we", 32'(mem_we), 32'(net_we));
            check("mem_addr", 32'(mem_addr), 32'(net_addr));
            if (net_we) check("mem_wdata", mem_wdata, net_wdata);
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
        end

        if (eg_core) begin
            if (core_we) exp_mem[core_addr] = core_wdata;
            else sb.push_back('{who: OWN_CORE, data: exp_mem[core_addr], due: cyc + 1});
        end
        if (eg_net) begin
            if (net_we) exp_mem[net_addr] = net_wdata;
            else sb.push_back('{who: OWN_NET, data: exp_mem[net_addr], due: cyc + 1});
        end

        if (!n_reset || !net_req || eg_net) net_wait = 0;
        else if (net_wait < SMAX)          net_wait++;
        last_core_gnt = eg_core;
        last_net_gnt  = eg_net;
    endtask

    task automatic step();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read responses due this cycle, delivered to the right owner only.
    always @(negedge clk) begin : monitor
        arb_owner_e    ew;
        logic [DW-1:0] ed;
        ew = OWN_NONE;
        ed = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            ew = sb[0].who;
            ed = sb[0].data;
            void'(sb.pop_front());
        end
        check("core_rvalid", 32'(core_rvalid), 32'(ew == OWN_CORE));
        check("net_rvalid", 32'(net_rvalid), 32'(ew == OWN_NET));
        if (ew == OWN_CORE) check("core_rdata", core_rdata, ed);
        if (ew == OWN_NET)  check("net_rdata", net_rdata, ed);
        if (!n_reset) begin
            check("core_rdata_rst", core_rdata, '0);
            check("net_rdata_rst", net_rdata, '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        for (int unsigned i = 0; i < (1 << AW); i++) begin
            v = $urandom;
            mem[i] <= v;
            exp_mem[i] = v;
        end
        mem[5] <= 32'hDEAD_BEEF;
        exp_mem[5] = 32'hDEAD_BEEF;

        // Reset with both requesters active: nothing may be granted.
        n_reset = 1'b0;
        core_state = RUN;
        set_core(1'b1, 1'b1, 10'h001, 32'h1111_1111);
        set_net(1'b1, 1'b1, 10'h002, 32'h2222_2222);
        @(posedge clk); #1;
        step();
        step();
        n_reset = 1'b1;

        // IDLE: network wins, core stalls; read of 0x005 returns next cycle.
        core_state = IDLE;
        set_core(1'b1, 1'b0, 10'h0AA, '0);
        set_net(1'b1, 1'b0, 10'h005, '0);
        step();
        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b0, 1'b0, '0, '0);
        step();

        // RUN with both requesting continuously for 20 cycles.
        core_state = RUN;
        dut_net_gnts = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0 || last_core_gnt) set_core(1'b1, 1'b0, AW'($urandom), '0);
            if (i == 0 || last_net_gnt)  set_net(1'b1, 1'b0, AW'($urandom), '0);
            step();
        end
`ifdef ARB_STARVE_EN
        check("starve_net_grants", 32'(dut_net_gnts), 32'd4);
`else
        check("strict_net_grants", 32'(dut_net_gnts), 32'd0);
`endif
        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b0, 1'b0, '0, '0);
        step();
        step();

        // Alternating owners: core read 0x010, then net read 0x020.
        set_core(1'b1, 1'b0, 10'h010, '0);
        step();
        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b1, 1'b0, 10'h020, '0);
        step();
        set_net(1'b0, 1'b0, '0, '0);
        step();
        step();

        // ERR: core ignored, network write lands in memory, no read data.
        core_state = ERR;
        set_core(1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF);
        set_net(1'b1, 1'b1, 10'h3FF, 32'h0000_1234);
        step();
        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b0, 1'b0, '0, '0);
        step();
        check("err_mem_write", mem[10'h3FF], 32'h0000_1234);
        core_state = IDLE;
        set_net(1'b1, 1'b0, 10'h3FF, '0);
        step();
        set_net(1'b0, 1'b0, '0, '0);
        step();

        // Build up network waiting, end on a core read grant, then reset.
        core_state = RUN;
        set_net(1'b1, 1'b0, 10'h066, '0);
        for (int i = 0; i < 4; i++) begin
            set_core(1'b1, 1'b0, AW'(10'h050 + i), '0);
            step();
        end
        n_reset = 1'b0;
        sb.delete();
        set_core(1'b1, 1'b0, 10'h055, '0);
        step();
        n_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (last_core_gnt) set_core(1'b1, 1'b0, AW'($urandom), '0);
            if (last_net_gnt)  set_net(1'b1, 1'b0, AW'($urandom), '0);
            step();
        end

        // Random traffic with mid-stream state changes.
        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       core_state = IDLE;
                1:       core_state = ERR;
                default: core_state = RUN;
            endcase
            if (!core_req || last_core_gnt) begin
                set_core($urandom_range(0, 9) < 7, 1'($urandom), AW'($urandom), $urandom);
            end
            if (!net_req || last_net_gnt) begin
                set_net($urandom_range(0, 9) < 6, 1'($urandom), AW'($urandom), $urandom);
            end
            step();
        end

        set_core(1'b0, 1'b0, '0, '0);
        set_net(1'b0, 1'b0, '0, '0);
        step();
        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
